// File: rtl/add_tree_pkg.sv
// add_tree_pkg: shared sizing, term-count, extension and saturation-bound helpers for the add tree.
package add_tree_pkg;

   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int terms(input int n, input int l);
      return (n + (1 << l) - 1) >> l;
   endfunction

   function automatic int full_w(input int bi, input int n);
      return bi + clog2(n);
   endfunction

   function automatic logic ext_bit(input logic msb, input int sg);
      return msb & (sg != 0);
   endfunction

   function automatic logic [63:0] sat_max(input int w, input int sg);
      return (sg != 0) ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int w, input int sg);
      return (sg != 0) ? ~64'd0 << (w - 1) : 64'd0;
   endfunction

endpackage

// File: rtl/add_tree_pipe_level.sv
// add_tree_level: one registered reduction level; an odd last term passes through unchanged.
// A level whose output width is narrower than its sum wraps, or clamps under ADD_TREE_SATURATE_EN.
module add_tree_level
   import add_tree_pkg::*;
#(
   parameter int TI = 2,
   parameter int W = 8,
   parameter int SIGNED = 1,
   parameter int OW = 8,
   localparam int TO = (TI + 1) / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic [TI*W-1:0]  in,
   output logic             out_valid,
   output logic [TO*OW-1:0] out,
   output logic             sat
);
   localparam logic [63:0] MX = sat_max(OW, SIGNED);
   localparam logic [63:0] MN = sat_min(OW, SIGNED);
   logic [TO*OW-1:0] nxt, data_d, data_q;
   logic [TO-1:0] ovf;
   logic valid_d, valid_q, sat_d, sat_q;
   for (genvar k = 0; k < TO; k++) begin : g_t
      logic [W-1:0] s;
      if (2 * k + 1 < TI) begin : g_add
         assign s = in[2*k*W +: W] + in[(2*k+1)*W +: W];
      end else begin : g_pass
         assign s = in[2*k*W +: W];
      end
      if (OW == W) begin : g_eq
         assign nxt[k*OW +: OW] = s;
         assign ovf[k] = 1'b0;
      end else if (OW > W) begin : g_ext
         assign nxt[k*OW +: OW] = {{(OW - W){ext_bit(s[W-1], SIGNED)}}, s};
         assign ovf[k] = 1'b0;
      end else begin : g_cut
`ifdef ADD_TREE_SATURATE_EN
         // overflow when the dropped high bits are not a pure extension of the kept result
         assign ovf[k] = (SIGNED != 0) ? (s[W-1:OW-1] != {(W - OW + 1){s[W-1]}}) : |s[W-1:OW];
         assign nxt[k*OW +: OW] = !ovf[k] ? s[OW-1:0] : ((SIGNED != 0) && s[W-1]) ? MN[OW-1:0] : MX[OW-1:0];
`else
         assign ovf[k] = 1'b0;
         assign nxt[k*OW +: OW] = s[OW-1:0];
`endif
      end
   end
   always_comb begin
      valid_d = en ? in_valid : valid_q;
      data_d = (en && in_valid) ? nxt : data_q;
      sat_d = (en && in_valid) ? |ovf : sat_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q <= '0;
         sat_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q <= data_d;
         sat_q <= sat_d;
      end
   end
   assign out_valid = valid_q;
   assign out = data_q;
   assign sat = sat_q;
endmodule

// File: rtl/add_tree_pipe.sv
// add_tree_pipe: pipelined valid/ready sum of NUMBER_INPUT operands via a registered binary tree.
// Optional ADD_TREE_SATURATE_EN clamps a narrow output and adds the sat port.
module add_tree_pipe
   import add_tree_pkg::*;
#(
   parameter int NUMBER_INPUT = 8,
   parameter int BIT_INPUT = 21,
   parameter int BIT_OUTPUT = 28,
   parameter int SIGNED = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUMBER_INPUT*BIT_INPUT-1:0] in,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [BIT_OUTPUT-1:0]             out,
   output logic                              out_valid,
   input  logic                              out_ready
`ifdef ADD_TREE_SATURATE_EN
   ,
   output logic                              sat
`endif
);
   localparam int N = NUMBER_INPUT;
   localparam int LEVELS = clog2(N);
   localparam int FULL_W = full_w(BIT_INPUT, N);
   logic stall;
   logic [N*FULL_W-1:0] op_ext, data0_d, data0_q;
   logic valid0_d, valid0_q;
   assign stall = out_valid && !out_ready;
   assign in_ready = !stall;
   for (genvar k = 0; k < N; k++) begin : g_op
      assign op_ext[k*FULL_W +: FULL_W] = {{LEVELS{ext_bit(in[(k+1)*BIT_INPUT-1], SIGNED)}}, in[k*BIT_INPUT +: BIT_INPUT]};
   end
   always_comb begin
      valid0_d = stall ? valid0_q : in_valid;
      data0_d = (!stall && in_valid) ? op_ext : data0_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid0_q <= 1'b0;
         data0_q <= '0;
      end else begin
         valid0_q <= valid0_d;
         data0_q <= data0_d;
      end
   end
   // only the last level resizes to BIT_OUTPUT; inner levels keep the exact FULL_W width
   for (genvar l = 1; l <= LEVELS; l++) begin : g_l
      localparam int OW = (l == LEVELS) ? BIT_OUTPUT : FULL_W;
      logic [terms(N, l)*OW-1:0] d;
      logic [terms(N, l - 1)*FULL_W-1:0] di;
      logic v, vi, st;
      if (l == 1) begin : g_src
         assign di = data0_q;
         assign vi = valid0_q;
      end else begin : g_src
         assign di = g_l[l-1].d;
         assign vi = g_l[l-1].v;
      end
      add_tree_level #(
         .TI(terms(N, l - 1)),
         .W(FULL_W),
         .SIGNED(SIGNED),
         .OW(OW)
      ) u_lvl (
         .clk(clk),
         .rst_n(rst_n),
         .en(!stall),
         .in_valid(vi),
         .in(di),
         .out_valid(v),
         .out(d),
         .sat(st)
      );
   end
   assign out = g_l[LEVELS].d;
   assign out_valid = g_l[LEVELS].v;
`ifdef ADD_TREE_SATURATE_EN
   assign sat = g_l[LEVELS].st;
`endif
endmodule

// File: tb/tb_add_tree_pipe.sv
// tb_add_tree_pipe: directed and random checks of add_tree_pipe (N=8, N=5, and a 22-bit output build).
module tb_add_tree_pipe;
   localparam int N = 8;
   localparam int BI = 21;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N*BI-1:0] in = '0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic in_ready, out_valid, in_ready5, out_valid5, in_ready22, out_valid22;
   logic [27:0] out, out5, c_out, c_out5;
   logic [21:0] out22, c_out22;
   logic c_v5, c_v22;
   logic [N*BI-1:0] c_in;
`ifdef ADD_TREE_SATURATE_EN
   logic sat, sat5, sat22, c_sat, c_sat5, c_sat22;
`endif
   int n_assert = 0;
   int n_fail = 0;
   logic [N*BI-1:0] q[$];

   always #5 clk = ~clk;

   add_tree_pipe #(.NUMBER_INPUT(8), .BIT_INPUT(BI), .BIT_OUTPUT(28), .SIGNED(1)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .out(out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ADD_TREE_SATURATE_EN
      , .sat(sat)
`endif
   );
   add_tree_pipe #(.NUMBER_INPUT(5), .BIT_INPUT(BI), .BIT_OUTPUT(28), .SIGNED(1)) dut5 (
      .clk(clk), .rst_n(rst_n), .in(in[5*BI-1:0]), .in_valid(in_valid), .in_ready(in_ready5),
      .out(out5), .out_valid(out_valid5), .out_ready(out_ready)
`ifdef ADD_TREE_SATURATE_EN
      , .sat(sat5)
`endif
   );
   add_tree_pipe #(.NUMBER_INPUT(8), .BIT_INPUT(BI), .BIT_OUTPUT(22), .SIGNED(1)) dut22 (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready22),
      .out(out22), .out_valid(out_valid22), .out_ready(out_ready)
`ifdef ADD_TREE_SATURATE_EN
      , .sat(sat22)
`endif
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint sum_of(input logic [N*BI-1:0] b, input int n);
      longint s = 0;
      for (int i = 0; i < n; i++) s += longint'($signed(b[i*BI +: BI]));
      return s;
   endfunction

   // the mathematically exact sum mapped onto a w-bit signed output
   function automatic longint fit(input longint s, input int w, output bit clamp);
      longint hi = (longint'(1) << (w - 1)) - 1;
      longint lo = -(longint'(1) << (w - 1));
      clamp = 1'b0;
`ifdef ADD_TREE_SATURATE_EN
      if (s > hi) begin
         clamp = 1'b1;
         return hi;
      end
      if (s < lo) begin
         clamp = 1'b1;
         return lo;
      end
      return s;
`else
      s = s & ((longint'(1) << w) - 1);
      if (s > hi) s -= longint'(1) << w;
      return s;
`endif
   endfunction

   task automatic cyc(output bit acc);
      bit ret, cl;
      longint s8;
      logic [N*BI-1:0] b;
      @(negedge clk);
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      chk("in_ready5", in_ready5, !(out_valid5 && !out_ready));
      chk("in_ready22", in_ready22, !(out_valid22 && !out_ready));
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      c_in = in;
      c_out = out;
      c_out5 = out5;
      c_out22 = out22;
      c_v5 = out_valid5;
      c_v22 = out_valid22;
`ifdef ADD_TREE_SATURATE_EN
      c_sat = sat;
      c_sat5 = sat5;
      c_sat22 = sat22;
`endif
      @(posedge clk);
      #1;
      if (acc) q.push_back(c_in);
      if (ret) begin
         chk("beat_expected", q.size() > 0, 1);
         if (q.size() > 0) begin
            b = q.pop_front();
            s8 = sum_of(b, 8);
            chk("sum8", $signed(c_out), s8);
            chk("valid5", c_v5, 1);
            chk("sum5", $signed(c_out5), sum_of(b, 5));
            chk("valid22", c_v22, 1);
            chk("out22", $signed(c_out22), fit(s8, 22, cl));
`ifdef ADD_TREE_SATURATE_EN
            chk("sat8", c_sat, 0);
            chk("sat5", c_sat5, 0);
            chk("sat22", c_sat22, cl);
`endif
         end
      end
   endtask

   task automatic fill(input int v);
      for (int k = 0; k < N; k++) in[k*BI +: BI] = 21'(v);
   endtask

   initial begin
      bit a;
      int v, c;
      #1;
      chk("rst_out", out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // single beat, latency and hold
      for (int k = 0; k < N; k++) in[k*BI +: BI] = 21'(k + 1);
      in_valid = 1'b1;
      cyc(a);
      in_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("lat%0d", k), out_valid, k == 4);
         if (k == 4) chk("basic36", $signed(out), 36);
         if (k == 5) chk("hold36", $signed(out), 36);
         if (k < 6) cyc(a);
      end
      // extremes and the odd-count operand pattern, back to back
      in_valid = 1'b1;
      fill(-1048576);
      cyc(a);
      fill(1048575);
      cyc(a);
      for (int k = 0; k < N; k++) in[k*BI +: BI] = 21'(10 * (k + 1));
      cyc(a);
      in_valid = 1'b0;
      repeat (6) cyc(a);
      // backpressure stream of 10 beats
      v = 0;
      c = 0;
      while ((v < 10 || q.size() > 0) && c < 60) begin
         fill(v);
         in_valid = v < 10;
         out_ready = !(c >= 6 && c <= 9);
         #1;
         if (c == 7) chk("stall_in_ready", in_ready, 0);
         cyc(a);
         if (a) v++;
         c++;
      end
      chk("bp_done", c < 60, 1);
      out_ready = 1'b1;
      // random traffic with random backpressure
      repeat (300) begin
         for (int k = 0; k < N; k++)
            in[k*BI +: BI] = ($urandom_range(0, 5) == 0) ? ($urandom_range(0, 1) ? 21'h100000 : 21'h0FFFFF) : 21'($urandom);
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         cyc(a);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (8) cyc(a);
      chk("drained", q.size(), 0);
      // reset with three beats in flight
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fill(100 + i);
         cyc(a);
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out", out, 0);
      chk("arst_in_ready", in_ready, 1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) cyc(a);
      chk("no_stale", out_valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
